// File: rtl/mem_access_wb.sv
// mem_access_wb: memory-access / writeback stage of the RV32I pipeline.
// Latches execute results, runs loads and stores over a req/ack data bus,
// aligns and extends load data, and drives the register-file write triple.
module mem_access_wb (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        E_VALID,
  input  logic [6:0]  E_OPCODE,
  input  logic [2:0]  E_FUNCT3,
  input  logic [4:0]  E_REG_D,
  input  logic [31:0] E_RESULT,
  input  logic [31:0] E_STORE_V,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [3:0]  MEM_WSTRB,
  output logic [31:0] MEM_WDATA,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA,
  output logic        MEM_WAIT,
  output logic        M_VALID,
  output logic [4:0]  M_REG_D,
  output logic [31:0] M_REG_D_V
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // funct3 encodings shared by loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE, DONE} state_t;

  // Stage register
  logic        valid_q;
  logic [6:0]  opcode_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;
  logic [31:0] result_q;
  logic [31:0] store_v_q;

  state_t      state_q, state_d;
  logic [31:0] rdata_q;

  logic        is_load, is_store, mem_op, writes_rd;
  logic [1:0]  byte_off;
  logic [31:0] load_data;
  logic        ack_take;

  // Stage register: captures the execute result whenever the pipeline advances.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q   <= 1'b0;
      opcode_q  <= '0;
      funct3_q  <= '0;
      rd_q      <= '0;
      result_q  <= '0;
      store_v_q <= '0;
    end else if (!STALL) begin
      valid_q   <= E_VALID;
      opcode_q  <= E_OPCODE;
      funct3_q  <= E_FUNCT3;
      rd_q      <= E_REG_D;
      result_q  <= E_RESULT;
      store_v_q <= E_STORE_V;
    end
  end

  assign is_load   = (opcode_q == OPC_LOAD);
  assign is_store  = (opcode_q == OPC_STORE);
  assign mem_op    = valid_q & (is_load | is_store);
  assign byte_off  = result_q[1:0];
  assign ack_take  = MEM_REQ & MEM_ACK;

  // Access FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Access FSM next state: a new instruction always restarts in IDLE; an
  // accepted ACK moves to DONE and parks there until the stage advances.
  // NOTE: state_d gets a default first so no path through the block leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (!STALL)
      state_d = IDLE;
    else if (state_q == IDLE && ack_take)
      state_d = DONE;
  end

  // Read-data capture on the accepted ACK edge; ACK without REQ is ignored.
  always_ff @(posedge CLK) begin
    if (RST)                            rdata_q <= '0;
    else if (state_q == IDLE && ack_take) rdata_q <= MEM_RDATA;
  end

  assign MEM_REQ  = mem_op & (state_q == IDLE);
  assign MEM_WAIT = mem_op & (state_q != DONE);
  assign MEM_WE   = is_store;
  assign MEM_ADDR = {result_q[31:2], 2'b00};

  // Store lane strobes and lane-replicated write data.
  always_comb begin
    MEM_WSTRB = 4'b0000;
    MEM_WDATA = store_v_q;
    if (is_store) begin
      case (funct3_q)
        F3_B: begin
          MEM_WSTRB = 4'b0001 << byte_off;
          MEM_WDATA = {4{store_v_q[7:0]}};
        end
        F3_H: begin
          MEM_WSTRB = byte_off[1] ? 4'b1100 : 4'b0011;
          MEM_WDATA = {2{store_v_q[15:0]}};
        end
        F3_W:    MEM_WSTRB = 4'b1111;
        default: MEM_WSTRB = 4'b0000;
      endcase
    end
  end

  // Load alignment: pick the addressed byte/half, then sign- or zero-extend.
  always_comb begin
    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    case (byte_off)
      2'd0:    sel_b = rdata_q[7:0];
      2'd1:    sel_b = rdata_q[15:8];
      2'd2:    sel_b = rdata_q[23:16];
      default: sel_b = rdata_q[31:24];
    endcase
    sel_h = byte_off[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (funct3_q)
      F3_B:    load_data = {{24{sel_b[7]}}, sel_b};
      F3_H:    load_data = {{16{sel_h[15]}}, sel_h};
      F3_BU:   load_data = {24'd0, sel_b};
      F3_HU:   load_data = {16'd0, sel_h};
      default: load_data = rdata_q;
    endcase
  end

  // Only register-writing opcodes name a destination; the rest report x0.
  always_comb begin
    case (opcode_q)
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC,
      OPC_JAL, OPC_JALR, OPC_LOAD: writes_rd = 1'b1;
      default:                     writes_rd = 1'b0;
    endcase
  end

  assign M_VALID   = valid_q & (!mem_op | (state_q == DONE));
  assign M_REG_D   = writes_rd ? rd_q : 5'd0;
  assign M_REG_D_V = !M_VALID ? 32'd0 : (is_load ? load_data : result_q);

endmodule

// File: tb/tb_mem_access_wb.sv
// Directed self-checking bench for mem_access_wb.
module tb_mem_access_wb;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ext_stall = 1'b0;
  logic        stall;
  logic        e_valid = 1'b0;
  logic [6:0]  e_opcode = '0;
  logic [2:0]  e_funct3 = '0;
  logic [4:0]  e_reg_d = '0;
  logic [31:0] e_result = '0;
  logic [31:0] e_store_v = '0;
  logic        mem_req, mem_we, mem_wait, m_valid;
  logic [31:0] mem_addr, mem_wdata, m_reg_d_v;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [4:0]  m_reg_d;

  int n_checks = 0;
  int n_fail   = 0;
  int commits  = 0;
  int start_commits;

  // The global stall must include the stage's own wait request.
  assign stall = mem_wait | ext_stall;

  mem_access_wb dut (
    .CLK(CLK), .RST(RST), .STALL(stall),
    .E_VALID(e_valid), .E_OPCODE(e_opcode), .E_FUNCT3(e_funct3),
    .E_REG_D(e_reg_d), .E_RESULT(e_result), .E_STORE_V(e_store_v),
    .MEM_REQ(mem_req), .MEM_WE(mem_we), .MEM_ADDR(mem_addr),
    .MEM_WSTRB(mem_wstrb), .MEM_WDATA(mem_wdata),
    .MEM_ACK(mem_ack), .MEM_RDATA(mem_rdata), .MEM_WAIT(mem_wait),
    .M_VALID(m_valid), .M_REG_D(m_reg_d), .M_REG_D_V(m_reg_d_v)
  );

  always #5 CLK = ~CLK;

  // Decode-side commit counter: one write per M_VALID & !STALL edge.
  always @(posedge CLK)
    if (!RST && m_valid && !stall) commits <= commits + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] res, input logic [31:0] sv);
    e_valid = v; e_opcode = op; e_funct3 = f3;
    e_reg_d = rd; e_result = res; e_store_v = sv;
  endtask

  task automatic bubble();
    drive(1'b0, 7'd0, 3'd0, 5'd0, 32'd0, 32'd0);
  endtask

  // Load rd=3 from 0x102 returning 0x00800000 after 'delay' wait cycles.
  task automatic do_lb(input string tag, input logic [2:0] f3, input int delay,
                       input logic [31:0] exp_v);
    int waits;
    waits = 0;
    drive(1'b1, OPC_LOAD, f3, 5'd3, 32'h0000_0102, 32'd0);
    tick();
    bubble();
    for (int i = 0; i <= delay; i++) begin
      if (i == delay) begin
        mem_ack = 1'b1; mem_rdata = 32'h0080_0000;
      end
      @(negedge CLK);
      if (mem_wait) waits++;
      if (i == 0) begin
        check({tag, "_req"},  32'(mem_req), 32'd1);
        check({tag, "_we"},   32'(mem_we), 32'd0);
        check({tag, "_addr"}, mem_addr, 32'h0000_0100);
      end
      check({tag, "_busy_valid"}, 32'(m_valid), 32'd0);
      tick();
      mem_ack = 1'b0; mem_rdata = 32'd0;
    end
    @(negedge CLK);
    check({tag, "_wait_cycles"}, 32'(waits), 32'(delay + 1));
    check({tag, "_done_wait"}, 32'(mem_wait), 32'd0);
    check({tag, "_valid"}, 32'(m_valid), 32'd1);
    check({tag, "_rd"},    32'(m_reg_d), 32'd3);
    check({tag, "_val"},   m_reg_d_v, exp_v);
    tick();
    @(negedge CLK);
    check({tag, "_after_valid"}, 32'(m_valid), 32'd0);
    tick();
  endtask

  // Store with rd field 12 (must not be written back); ACK after 'delay' cycles.
  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] data, input int delay,
                          input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
    drive(1'b1, OPC_STORE, f3, 5'd12, addr, data);
    tick();
    bubble();
    for (int i = 0; i <= delay; i++) begin
      if (i == delay) mem_ack = 1'b1;
      @(negedge CLK);
      check({tag, "_req"},   32'(mem_req), 32'd1);
      check({tag, "_we"},    32'(mem_we), 32'd1);
      check({tag, "_addr"},  mem_addr, {addr[31:2], 2'b00});
      check({tag, "_strb"},  32'(mem_wstrb), 32'(exp_strb));
      check({tag, "_wdata"}, mem_wdata, exp_wdata);
      check({tag, "_wait"},  32'(mem_wait), 32'd1);
      tick();
      mem_ack = 1'b0;
    end
    @(negedge CLK);
    check({tag, "_done_req"},  32'(mem_req), 32'd0);
    check({tag, "_done_wait"}, 32'(mem_wait), 32'd0);
    check({tag, "_valid"},     32'(m_valid), 32'd1);
    check({tag, "_rd"},        32'(m_reg_d), 32'd0);
    tick();
  endtask

  initial begin
    // Reset
    tick();
    @(negedge CLK);
    check("rst_req",   32'(mem_req), 32'd0);
    check("rst_wait",  32'(mem_wait), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_rd",    32'(m_reg_d), 32'd0);
    check("rst_val",   m_reg_d_v, 32'd0);
    tick();
    RST = 1'b0;

    // 1. ALU writeback
    drive(1'b1, OPC_OP, 3'd0, 5'd5, 32'h0000_1234, 32'd0);
    tick();
    bubble();
    @(negedge CLK);
    check("add_valid", 32'(m_valid), 32'd1);
    check("add_rd",    32'(m_reg_d), 32'd5);
    check("add_val",   m_reg_d_v, 32'h0000_1234);
    check("add_req",   32'(mem_req), 32'd0);
    tick();

    // Branch: valid but no destination
    drive(1'b1, OPC_BRANCH, 3'd0, 5'd4, 32'h0000_0088, 32'd0);
    tick();
    bubble();
    @(negedge CLK);
    check("br_valid", 32'(m_valid), 32'd1);
    check("br_rd",    32'(m_reg_d), 32'd0);
    check("br_val",   m_reg_d_v, 32'h0000_0088);
    tick();

    // 2. LB / LBU with ACK after 3 cycles, plus LH and LW with quicker ACKs
    do_lb("lb",  3'b000, 3, 32'hFFFF_FF80);
    do_lb("lbu", 3'b100, 3, 32'h0000_0080);
    do_lb("lh",  3'b001, 0, 32'h0000_0080);
    do_lb("lw",  3'b010, 1, 32'h0080_0000);

    // 3. Stores
    do_store("sh",  3'b001, 32'h0000_0206, 32'hABCD_5678, 1, 4'b1100, 32'h5678_5678);
    do_store("sb",  3'b000, 32'h0000_0001, 32'h0000_00A5, 0, 4'b0010, 32'hA5A5_A5A5);
    do_store("sw",  3'b010, 32'h0000_0013, 32'h1357_9BDF, 0, 4'b1111, 32'h1357_9BDF);
    do_store("sx",  3'b011, 32'h0000_0020, 32'h0000_0001, 0, 4'b0000, 32'h0000_0001);

    // 4. External stall holds an ALU writeback; exactly one commit
    drive(1'b1, OPC_OP_IMM, 3'd0, 5'd7, 32'h0000_CAFE, 32'd0);
    tick();
    bubble();
    start_commits = commits;
    ext_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("stall_valid", 32'(m_valid), 32'd1);
      check("stall_rd",    32'(m_reg_d), 32'd7);
      check("stall_val",   m_reg_d_v, 32'h0000_CAFE);
      tick();
    end
    ext_stall = 1'b0;
    tick();
    check("stall_commits", 32'(commits - start_commits), 32'd1);
    @(negedge CLK);
    check("stall_after_valid", 32'(m_valid), 32'd0);
    tick();

    // 5. Reset during an outstanding request, then a late ACK
    drive(1'b1, OPC_LOAD, 3'b010, 5'd9, 32'h0000_0400, 32'd0);
    tick();
    bubble();
    @(negedge CLK);
    check("rstreq_req_before", 32'(mem_req), 32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    @(negedge CLK);
    check("rstreq_req",   32'(mem_req), 32'd0);
    check("rstreq_valid", 32'(m_valid), 32'd0);
    check("rstreq_wait",  32'(mem_wait), 32'd0);
    tick();
    mem_ack = 1'b0; mem_rdata = 32'd0;
    @(negedge CLK);
    check("late_ack_valid", 32'(m_valid), 32'd0);
    check("late_ack_val",   m_reg_d_v, 32'd0);
    tick();

    // 6. Back-to-back LW, ACK in the first cycle of each
    drive(1'b1, OPC_LOAD, 3'b010, 5'd10, 32'h0000_0300, 32'd0);
    tick();
    drive(1'b1, OPC_LOAD, 3'b010, 5'd11, 32'h0000_0304, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    @(negedge CLK);
    check("b2b1_req",  32'(mem_req), 32'd1);
    check("b2b1_addr", mem_addr, 32'h0000_0300);
    check("b2b1_wait", 32'(mem_wait), 32'd1);
    tick();
    mem_rdata = 32'hDEAD_BEEF;  // ACK with no request: must be ignored
    @(negedge CLK);
    check("b2b1_req_done", 32'(mem_req), 32'd0);
    check("b2b1_valid",    32'(m_valid), 32'd1);
    check("b2b1_rd",       32'(m_reg_d), 32'd10);
    check("b2b1_val",      m_reg_d_v, 32'h1111_1111);
    tick();
    bubble();
    mem_rdata = 32'h2222_2222;
    @(negedge CLK);
    check("b2b2_req",   32'(mem_req), 32'd1);
    check("b2b2_addr",  mem_addr, 32'h0000_0304);
    check("b2b2_busy",  32'(m_valid), 32'd0);
    tick();
    mem_ack = 1'b0; mem_rdata = 32'd0;
    @(negedge CLK);
    check("b2b2_valid", 32'(m_valid), 32'd1);
    check("b2b2_rd",    32'(m_reg_d), 32'd11);
    check("b2b2_val",   m_reg_d_v, 32'h2222_2222);
    tick();
    @(negedge CLK);
    check("b2b_end_valid", 32'(m_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
